// File: rtl/cordic_angle_seq.sv
// -----------------------------------------------------------------------------
// cordic_angle_seq
//   Front-end sequencer for a CORDIC cosine core whose convergence range is
//   [-pi/2, pi/2]. A full-range Q3.13 angle is accepted, wrapped to [-pi, pi],
//   then folded into the core's range. The folded angle is sent to the core as
//   a Q2.14 theta together with a one-cycle start pulse. The sequencer waits for
//   a rising edge on the core's fin, fixes the sign of the cosine when the angle
//   was folded, and presents the result over a valid/ready handshake. If fin
//   never rises, a timeout result (cos 0, err 1) is presented instead.
//
// Ports
//   clk          in   rising-edge clock
//   rst_b        in   asynchronous active-low reset
//   in_vld       in   angle valid
//   in_rdy       out  idle, ready to accept an angle
//   angle        in   signed Q3.13 radians, [-4, 4)
//   out_vld      out  result valid
//   out_rdy      in   consumer accepts result
//   cos_out      out  signed Q2.14 cosine
//   err          out  result produced by timeout (qualified by out_vld)
//   cordic_theta out  Q2.14 angle to the core
//   cordic_bgn   out  one-cycle start pulse to the core
//   cordic_cos   in   cosine from the core
//   cordic_fin   in   done level from the core
// -----------------------------------------------------------------------------
module cordic_angle_seq #(
  parameter int DW  = 16,
  parameter int TMO = 31,
  parameter int TW  = 5
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic signed [DW-1:0] angle,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic signed [DW-1:0] cos_out,
  output logic                 err,
  output logic signed [DW-1:0] cordic_theta,
  output logic                 cordic_bgn,
  input  logic signed [DW-1:0] cordic_cos,
  input  logic                 cordic_fin
);

  // One extra bit of headroom so the wrap by 2*pi never overflows.
  localparam logic signed [DW:0] PI     = 17'sh06488;
  localparam logic signed [DW:0] HPI    = 17'sh03244;
  localparam logic signed [DW:0] TWO_PI = 17'sh0C910;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4,
    HOLD   = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic signed [DW-1:0] angle_q;
  logic                 neg;
  logic [TW-1:0]        cnt;
  logic                 fin_q;

  logic signed [DW:0]   a_ext, a_wrap, a_fold;
  logic                 neg_nxt;
  logic signed [DW-1:0] theta_nxt;
  logic                 fin_edge;
  logic                 timeout;

  // Negating the most negative code would wrap; clamp it to the largest positive.
  function automatic logic signed [DW-1:0] sat_neg(input logic signed [DW-1:0] x);
    if (x == {1'b1, {(DW-1){1'b0}}})
      return {1'b0, {(DW-1){1'b1}}};
    return -x;
  endfunction

  // Range reduction: wrap to [-pi, pi], then fold into [-pi/2, pi/2].
  // Strict comparisons: +/-HPI stays unfolded, exactly PI wraps/folds to 0.
  always_comb begin
    a_ext   = {angle_q[DW-1], angle_q};
    a_wrap  = a_ext;
    a_fold  = a_ext;
    neg_nxt = 1'b0;
    if (a_ext > PI)
      a_wrap = a_ext - TWO_PI;
    else if (a_ext < -PI)
      a_wrap = a_ext + TWO_PI;
    a_fold = a_wrap;
    if (a_wrap > HPI) begin
      a_fold  = a_wrap - PI;
      neg_nxt = 1'b1;
    end else if (a_wrap < -HPI) begin
      a_fold  = a_wrap + PI;
      neg_nxt = 1'b1;
    end
    // Q3.13 -> Q2.14; |a_fold| <= HPI so the shifted value fits.
    theta_nxt = {a_fold[DW-2:0], 1'b0};
  end

  assign fin_edge = cordic_fin & ~fin_q;
  assign timeout  = (cnt == TW'(TMO));

  always_comb begin
    state_nxt  = state;
    in_rdy     = 1'b0;
    out_vld    = 1'b0;
    cordic_bgn = 1'b0;
    unique case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) state_nxt = REDUCE;
      end
      REDUCE: state_nxt = START;
      START: begin
        cordic_bgn = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (fin_edge)
          state_nxt = DONE;
        else if (timeout)
          state_nxt = HOLD;
      end
      DONE: state_nxt = HOLD;
      HOLD: begin
        out_vld = 1'b1;
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      angle_q      <= '0;
      neg          <= 1'b0;
      cordic_theta <= '0;
      cnt          <= '0;
      fin_q        <= 1'b0;
      cos_out      <= '0;
      err          <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        // accept boundary
        IDLE: begin
          if (in_vld) angle_q <= angle;
        end
        // reduce -> core boundary: theta holds until the next accept
        REDUCE: begin
          cordic_theta <= theta_nxt;
          neg          <= neg_nxt;
        end
        // Seed fin_q with the current fin level so a fin already high at
        // bgn (left over from the last run, or stuck) is not taken as an edge.
        START: begin
          cnt   <= '0;
          fin_q <= cordic_fin;
        end
        WAIT: begin
          cnt   <= cnt + 1'b1;
          fin_q <= cordic_fin;
          if (!fin_edge && timeout) begin
            err     <= 1'b1;
            cos_out <= '0;
          end
        end
        // core -> output boundary
        DONE: begin
          cos_out <= neg ? sat_neg(cordic_cos) : cordic_cos;
          err     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
